uart_rx_ext: RTL and testbench

Parametrised successor to the fixed 8N1 uart_rx receiver. Adds configurable data width, optional odd/even parity, 1 or 2 stop bits and a metastability synchroniser. Reports parity error, framing error and line-break condition per frame. Drops in where uart_rx sits, i.e. the receive side of the UART loopback/register-access top, on the single system clock.

---
 rtl/uart_rx_ext.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_ext.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: configurable data width, optional parity, 1/2 stop bits,
// input synchroniser, and per-frame parity/framing/break status.
module uart_rx_ext #(
  parameter int DIVISOR      = 9,
  parameter int SAMPLE_PHASE = DIVISOR / 2,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_data_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] SAMPLE_C = CW'(SAMPLE_PHASE);
  localparam logic [CW-1:0] WRAP_C   = CW'(DIVISOR - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK_WAIT} state_t;

  state_t                state_q, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  rx_s;
  logic [CW-1:0]         cnt_q, cnt_nx;
  logic [IW-1:0]         idx_q, idx_nx;
  logic [DATA_BITS-1:0]  shreg_q, shreg_nx;
  logic                  perr_q, perr_nx;
  logic                  ferr_q, ferr_nx;
  logic                  zero_q, zero_nx;
  logic [DATA_BITS-1:0]  data_nx;
  logic                  valid_nx, perr_out_nx, ferr_out_nx, brk_nx;
  logic                  sample, wrap, parity_exp, stop_ferr, stop_zero;

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign sample     = (cnt_q == SAMPLE_C);
  assign wrap       = (cnt_q == WRAP_C);
  assign parity_exp = (PARITY == 1) ? ~^shreg_q : ^shreg_q;
  assign stop_ferr  = ferr_q | ~rx_s;
  assign stop_zero  = zero_q & ~rx_s;
  assign o_busy     = (state_q != IDLE);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx    = state_q;
    cnt_nx      = wrap ? '0 : cnt_q + CW'(1);
    idx_nx      = idx_q;
    shreg_nx    = shreg_q;
    perr_nx     = perr_q;
    ferr_nx     = ferr_q;
    zero_nx     = zero_q;
    data_nx     = o_data;
    valid_nx    = 1'b0;
    perr_out_nx = 1'b0;
    ferr_out_nx = 1'b0;
    brk_nx      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_nx = '0;
        if (!rx_s) begin
          state_nx = START;
          idx_nx   = '0;
          perr_nx  = 1'b0;
          ferr_nx  = 1'b0;
          zero_nx  = 1'b1;
        end
      end
      START: begin
        if (sample && rx_s) state_nx = IDLE;
        else if (wrap)      state_nx = DATA;
      end
      DATA: begin
        if (sample) begin
          shreg_nx = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (rx_s) zero_nx = 1'b0;
        end
        if (wrap) begin
          if (idx_q == LAST_DATA) begin
            idx_nx   = '0;
            state_nx = (PARITY != 0) ? PAR : STOP;
          end else begin
            idx_nx = idx_q + IW'(1);
          end
        end
      end
      PAR: begin
        if (sample) begin
          if (rx_s != parity_exp) perr_nx = 1'b1;
          if (rx_s) zero_nx = 1'b0;
        end
        if (wrap) state_nx = STOP;
      end
      STOP: begin
        if (wrap) idx_nx = idx_q + IW'(1);
        if (sample) begin
          ferr_nx = stop_ferr;
          zero_nx = stop_zero;
          // The last stop sample ends the frame immediately so a new start bit can follow.
          if (idx_q == LAST_STOP) begin
            valid_nx    = 1'b1;
            data_nx     = shreg_q;
            perr_out_nx = perr_q;
            ferr_out_nx = stop_ferr;
            brk_nx      = stop_zero;
            state_nx    = stop_zero ? BRK_WAIT : IDLE;
          end
        end
      end
      BRK_WAIT: begin
        cnt_nx = '0;
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_nx;
  end

  // NOTE: every flop here, shift register included, is cleared so an aborted frame leaves no residue.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      sync_q       <= '1;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      zero_q       <= 1'b0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], i_rx};
      cnt_q        <= cnt_nx;
      idx_q        <= idx_nx;
      shreg_q      <= shreg_nx;
      perr_q       <= perr_nx;
      ferr_q       <= ferr_nx;
      zero_q       <= zero_nx;
      o_data       <= data_nx;
      o_data_valid <= valid_nx;
      o_parity_err <= perr_out_nx;
      o_frame_err  <= ferr_out_nx;
      o_break      <= brk_nx;
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: even-parity/1-stop instance (a) and no-parity/2-stop instance (b).
module tb_uart_rx_ext;

  localparam int DIV = 9;
  // Edge of first low drive to the cycle o_data_valid is seen: 2 sync + 1 detect + 10*9 + 4 + 1.
  localparam int LAT = 98;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, perr_a, ferr_a, brk_a, busy_a;
  logic       valid_b, perr_b, ferr_b, brk_b, busy_b;

  uart_rx_ext #(.DIVISOR(DIV), .SAMPLE_PHASE(4), .DATA_BITS(8), .PARITY(2),
                .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .i_reset(rst_a), .i_rx(rx_a), .o_data(data_a), .o_data_valid(valid_a),
    .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_break(brk_a), .o_busy(busy_a));

  uart_rx_ext #(.DIVISOR(DIV), .SAMPLE_PHASE(4), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(2), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .i_reset(rst_b), .i_rx(rx_b), .o_data(data_b), .o_data_valid(valid_b),
    .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_break(brk_b), .o_busy(busy_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse capture: counts valid cycles and latches status seen alongside each pulse.
  int         pulses_a = 0, pulses_b = 0, busy_cyc_a = 0;
  int         last_cyc_a = 0, last_cyc_b = 0;
  logic [7:0] cap_data_a = '0, cap_data_b = '0;
  logic [2:0] cap_flags_a = '0, cap_flags_b = '0;

  always @(negedge clk) begin
    if (valid_a) begin
      pulses_a++;
      last_cyc_a  = cyc;
      cap_data_a  = data_a;
      cap_flags_a = {perr_a, ferr_a, brk_a};
    end
    if (valid_b) begin
      pulses_b++;
      last_cyc_b  = cyc;
      cap_data_b  = data_b;
      cap_flags_b = {perr_b, ferr_b, brk_b};
    end
    if (busy_a) busy_cyc_a++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  // Drives n bits LSB-first, one bit period each, then returns the line to idle.
  task automatic send(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(sel, bits[i]);
      repeat (DIV) @(posedge clk);
      #1;
    end
    set_line(sel, 1'b1);
  endtask

  int t0, p0, b0;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(posedge clk); #1;

    check("rst_data_a",  32'(data_a), 32'h0);
    check("rst_valid_a", 32'(valid_a), 32'h0);
    check("rst_busy_a",  32'(busy_a), 32'h0);
    check("rst_flags_a", 32'({perr_a, ferr_a, brk_a}), 32'h0);
    check("rst_data_b",  32'(data_b), 32'h0);
    check("rst_busy_b",  32'(busy_b), 32'h0);

    // Frame 1: 0xA5, even parity bit 0, valid stop.
    p0 = pulses_a;
    @(posedge clk); #1; t0 = cyc;
    send(0, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
    repeat (20) @(posedge clk); #1;
    check("f1_pulses", 32'(pulses_a - p0), 32'd1);
    check("f1_lat",    32'(last_cyc_a - t0), 32'(LAT));
    check("f1_data",   32'(cap_data_a), 32'hA5);
    check("f1_flags",  32'(cap_flags_a), 32'b000);
    check("f1_hold",   32'(data_a), 32'hA5);
    check("f1_idle",   32'(busy_a), 32'h0);

    // Frame 2: 0xA5 with wrong parity bit.
    p0 = pulses_a;
    @(posedge clk); #1; t0 = cyc;
    send(0, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11);
    repeat (20) @(posedge clk); #1;
    check("f2_pulses", 32'(pulses_a - p0), 32'd1);
    check("f2_lat",    32'(last_cyc_a - t0), 32'(LAT));
    check("f2_data",   32'(cap_data_a), 32'hA5);
    check("f2_flags",  32'(cap_flags_a), 32'b100);
    check("f2_perr_clr", 32'(perr_a), 32'h0);

    // Reset during the data bits, then a clean 0x55 frame.
    p0 = pulses_a;
    @(posedge clk); #1;
    send(0, 16'h0000, 5);
    @(posedge clk); #1; rst_a = 1'b1;
    @(posedge clk); #1; rst_a = 1'b0;
    check("rst_mid_busy", 32'(busy_a), 32'h0);
    check("rst_mid_data", 32'(data_a), 32'h0);
    repeat (80) @(posedge clk); #1;
    check("rst_mid_nopulse", 32'(pulses_a - p0), 32'd0);
    @(posedge clk); #1; t0 = cyc;
    send(0, {5'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11);
    repeat (20) @(posedge clk); #1;
    check("f55_pulses", 32'(pulses_a - p0), 32'd1);
    check("f55_lat",    32'(last_cyc_a - t0), 32'(LAT));
    check("f55_data",   32'(cap_data_a), 32'h55);
    check("f55_flags",  32'(cap_flags_a), 32'b000);

    // Instance b: 0x3C, second stop bit low.
    p0 = pulses_b;
    @(posedge clk); #1; t0 = cyc;
    send(1, {5'b0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    repeat (30) @(posedge clk); #1;
    check("f3_pulses", 32'(pulses_b - p0), 32'd1);
    check("f3_lat",    32'(last_cyc_b - t0), 32'(LAT));
    check("f3_data",   32'(cap_data_b), 32'h3C);
    check("f3_flags",  32'(cap_flags_b), 32'b010);
    check("f3_idle",   32'(busy_b), 32'h0);

    // Glitch: 3-clock low pulse is rejected at the start sample.
    p0 = pulses_a; b0 = busy_cyc_a;
    @(posedge clk); #1; rx_a = 1'b0;
    repeat (3) @(posedge clk); #1; rx_a = 1'b1;
    repeat (30) @(posedge clk); #1;
    check("glitch_nopulse", 32'(pulses_a - p0), 32'd0);
    check("glitch_busy_cyc", 32'(busy_cyc_a - b0), 32'd5);

    // Break: line low for 30 bit periods, then released.
    p0 = pulses_a;
    @(posedge clk); #1; t0 = cyc; rx_a = 1'b0;
    repeat (30 * DIV) @(posedge clk); #1;
    check("brk_pulses", 32'(pulses_a - p0), 32'd1);
    check("brk_lat",    32'(last_cyc_a - t0), 32'(LAT));
    check("brk_data",   32'(cap_data_a), 32'h00);
    check("brk_flags",  32'(cap_flags_a), 32'b011);
    check("brk_busy_held", 32'(busy_a), 32'h1);
    rx_a = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("brk_busy_rel", 32'(busy_a), 32'h0);
    check("brk_single",   32'(pulses_a - p0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
